xbar_rtn_rob: RTL and testbench
===============================

Name: xbar_rtn_rob

Overview:
- Return-path companion to the cross bar request path. The request side allocates a per-channel reorder-buffer (ROB) slot for every read it sends toward the HTU, and carries that slot number with the request.
- The slice cache (SC) returns data out of order, tagged with channel id and ROB number.
- This block stores each return in its slot and drains every channel strictly in allocation order onto that channel's mcash_chN_rtn_* port.
- Three channels are fixed (ch_id 0..2).

Parameters:
- ROB_DEPTH, 4, slots per channel; must be a power of two, at least 2.
- ROB_W, 2, log2(ROB_DEPTH); width of the ROB number.
- DATA_W, 128, return data width.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- xbar_rob_alloc_valid_i  in  1  request side wants a slot.
- xbar_rob_alloc_ch_id_i  in  2  channel to allocate in.
- xbar_rob_alloc_ready_o  out  1  the selected channel has a free slot.
- xbar_rob_alloc_num_o  out  ROB_W  slot number granted; equals that channel's alloc pointer.
- sc_xbar_valid_i  in  1  SC return valid.
- sc_xbar_ready_o  out  1  return accepted.
- sc_xbar_ch_id_i  in  2  return channel.
- sc_xbar_rob_num_i  in  ROB_W  return slot.
- sc_xbar_data_i  in  DATA_W  return data.
- mcash_ch0_rtn_valid_o / mcash_ch1_rtn_valid_o / mcash_ch2_rtn_valid_o  out  1 each  in-order return valid.
- mcash_ch0_rtn_ready_i / mcash_ch1_rtn_ready_i / mcash_ch2_rtn_ready_i  in  1 each  channel accepts the return.
- mcash_ch0_rtn_data_o / mcash_ch1_rtn_data_o / mcash_ch2_rtn_data_o  out  DATA_W each  return data.
- rob_err_o  out  1  sticky protocol-error flag.

Behaviour:
- Per-channel state:
  - alloc_ptr and head_ptr, each ROB_W bits, wrap modulo ROB_DEPTH.
  - count, ROB_W+1 bits, range 0..ROB_DEPTH.
  - Per-slot bits busy[] and filled[].
  - Data array of ROB_DEPTH x DATA_W.
- Reset (rst_i low, asynchronous):
  - All pointers, counts, busy and filled bits cleared; rob_err_o = 0.
  - All rtn_valid_o = 0; alloc_ready_o = 0 for an invalid ch_id.
  - Data array is not reset; rtn_data_o is don't-care while rtn_valid_o = 0.
  - Any in-flight returns are discarded.
- Allocation:
  - alloc_ready_o = (ch_id < 3) && (count[ch_id] < ROB_DEPTH).
  - The grant is combinational on ch_id; a same-cycle drain does not free a slot for the same cycle.
  - On valid && ready: busy[alloc_ptr] set, alloc_ptr incremented, count incremented.
- Return acceptance:
  - sc_xbar_ready_o = 1 whenever out of reset.
  - On valid, the return is legal only if ch_id < 3, the slot is busy, and the slot is not yet filled.
  - Legal return: data written and filled set at the next edge.
  - Illegal return: dropped, rob_err_o set to 1 and held until reset.
- Drain:
  - mcash_chN_rtn_valid_o = filled[head_ptr]; data = array[head_ptr]. Both come from registered state.
  - Latency from return acceptance at edge T to rtn_valid_o high is 1 cycle, even when the target slot is head.
  - On valid && ready: busy and filled cleared, head_ptr incremented, count decremented.
  - Valid and data stay stable while ready is low.
- Simultaneous events:
  - Allocate, return and drain in the same cycle on the same channel all take effect.
  - count changes by (+alloc − drain).
  - Allocation can never target the head slot while that slot is draining, because it is busy.
  - A return to a slot that is draining in the same cycle is an error (that slot is already filled).
- Each channel drains independently; a stalled channel never blocks the others.

Test Plan:
1. Reset, then alloc ch0 four times -> alloc_num 0,1,2,3; alloc_ready then 0. Returns to slots 2,0,3,1 with data A2,A0,A3,A1, rtn_ready=1 -> ch0 outputs A0,A1,A2,A3 in order. A0 appears 1 cycle after the slot-0 return; A1 appears 1 cycle after its return.
2. Alloc ch1 and ch2 one slot each; return to ch2 first with rtn_ready=0 on ch1 -> ch2 drains immediately; ch1 valid stays high with data stable until ready=1.
3. ch0 full, drain and alloc in the same cycle -> alloc_ready=0 that cycle and 1 the next; next alloc_num = 0 after wrap.
4. Return to a non-busy slot, a duplicate return, and ch_id=3 -> each is dropped, rob_err_o rises and stays 1; no rtn_valid change.
5. Assert rst_i low mid-drain with ch0 holding 3 filled slots -> rtn_valid 0 immediately (asynchronous); after release, alloc_num restarts at 0.

Source files
------------

// File: rtl/xbar_rtn_rob_if.sv
// Handshake bundle for the crossbar return path: ROB allocation, slice-cache returns
// and the three in-order per-channel return ports.
interface xbar_rtn_rob_if #(
  parameter int ROB_W  = 2,
  parameter int DATA_W = 128
);
  logic              xbar_rob_alloc_valid_i;
  logic [1:0]        xbar_rob_alloc_ch_id_i;
  logic              xbar_rob_alloc_ready_o;
  logic [ROB_W-1:0]  xbar_rob_alloc_num_o;

  logic              sc_xbar_valid_i;
  logic              sc_xbar_ready_o;
  logic [1:0]        sc_xbar_ch_id_i;
  logic [ROB_W-1:0]  sc_xbar_rob_num_i;
  logic [DATA_W-1:0] sc_xbar_data_i;

  logic              mcash_ch0_rtn_valid_o;
  logic              mcash_ch1_rtn_valid_o;
  logic              mcash_ch2_rtn_valid_o;
  logic              mcash_ch0_rtn_ready_i;
  logic              mcash_ch1_rtn_ready_i;
  logic              mcash_ch2_rtn_ready_i;
  logic [DATA_W-1:0] mcash_ch0_rtn_data_o;
  logic [DATA_W-1:0] mcash_ch1_rtn_data_o;
  logic [DATA_W-1:0] mcash_ch2_rtn_data_o;

  logic              rob_err_o;

  modport slave (
    input  xbar_rob_alloc_valid_i, xbar_rob_alloc_ch_id_i,
    output xbar_rob_alloc_ready_o, xbar_rob_alloc_num_o,
    input  sc_xbar_valid_i, sc_xbar_ch_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
    output sc_xbar_ready_o,
    output mcash_ch0_rtn_valid_o, mcash_ch1_rtn_valid_o, mcash_ch2_rtn_valid_o,
    input  mcash_ch0_rtn_ready_i, mcash_ch1_rtn_ready_i, mcash_ch2_rtn_ready_i,
    output mcash_ch0_rtn_data_o, mcash_ch1_rtn_data_o, mcash_ch2_rtn_data_o,
    output rob_err_o
  );

  modport master (
    output xbar_rob_alloc_valid_i, xbar_rob_alloc_ch_id_i,
    input  xbar_rob_alloc_ready_o, xbar_rob_alloc_num_o,
    output sc_xbar_valid_i, sc_xbar_ch_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
    input  sc_xbar_ready_o,
    input  mcash_ch0_rtn_valid_o, mcash_ch1_rtn_valid_o, mcash_ch2_rtn_valid_o,
    output mcash_ch0_rtn_ready_i, mcash_ch1_rtn_ready_i, mcash_ch2_rtn_ready_i,
    input  mcash_ch0_rtn_data_o, mcash_ch1_rtn_data_o, mcash_ch2_rtn_data_o,
    input  rob_err_o
  );
endinterface

// File: rtl/xbar_rtn_rob.sv
// Per-channel reorder buffer for slice-cache returns: out-of-order returns are parked in
// their allocated slot and each of the three channels drains strictly in allocation order.
module xbar_rtn_rob #(
  parameter int ROB_DEPTH = 4,
  parameter int ROB_W     = 2,
  parameter int DATA_W    = 128
) (
  input logic           clk_i,
  input logic           rst_i,
  xbar_rtn_rob_if.slave bus
);
  localparam int NCH = 3;
  localparam logic [ROB_W:0] FULL = (ROB_W+1)'(ROB_DEPTH);

  logic [ROB_W-1:0]     allocPtr_q [NCH];
  logic [ROB_W-1:0]     allocPtr_d [NCH];
  logic [ROB_W-1:0]     headPtr_q  [NCH];
  logic [ROB_W-1:0]     headPtr_d  [NCH];
  logic [ROB_W:0]       count_q    [NCH];
  logic [ROB_W:0]       count_d    [NCH];
  logic [ROB_DEPTH-1:0] busy_q     [NCH];
  logic [ROB_DEPTH-1:0] busy_d     [NCH];
  logic [ROB_DEPTH-1:0] filled_q   [NCH];
  logic [ROB_DEPTH-1:0] filled_d   [NCH];
  logic [DATA_W-1:0]    data_q     [NCH][ROB_DEPTH];
  logic                 robErr_q;
  logic                 robErr_d;

  logic [NCH-1:0]   allocHit;
  logic [NCH-1:0]   allocFire;
  logic [NCH-1:0]   retFire;
  logic [NCH-1:0]   drainFire;
  logic [NCH-1:0]   rtnValid;
  logic [NCH-1:0]   rtnReady;
  logic             allocReady;
  logic [ROB_W-1:0] allocNum;
  logic             retErr;

  // The grant looks only at registered count, so a drain in the same cycle cannot free a slot early.
  always_comb begin
    allocReady = 1'b0;
    allocNum   = '0;
    for (int c = 0; c < NCH; c++) begin
      allocHit[c] = (bus.xbar_rob_alloc_ch_id_i == 2'(c));
      if (allocHit[c]) begin
        allocReady = (count_q[c] < FULL);
        allocNum   = allocPtr_q[c];
      end
    end
  end

  assign allocFire = allocHit & {NCH{bus.xbar_rob_alloc_valid_i & allocReady}};

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      retFire[c] = bus.sc_xbar_valid_i
                   && (bus.sc_xbar_ch_id_i == 2'(c))
                   && busy_q[c][bus.sc_xbar_rob_num_i]
                   && !filled_q[c][bus.sc_xbar_rob_num_i];
      rtnValid[c] = filled_q[c][headPtr_q[c]];
    end
    retErr = bus.sc_xbar_valid_i && (retFire == '0);
  end

  assign rtnReady  = {bus.mcash_ch2_rtn_ready_i, bus.mcash_ch1_rtn_ready_i, bus.mcash_ch0_rtn_ready_i};
  assign drainFire = rtnValid & rtnReady;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      allocPtr_d[c] = allocPtr_q[c];
      headPtr_d[c]  = headPtr_q[c];
      busy_d[c]     = busy_q[c];
      filled_d[c]   = filled_q[c];
      if (allocFire[c]) begin
        busy_d[c][allocPtr_q[c]] = 1'b1;
        allocPtr_d[c]            = allocPtr_q[c] + ROB_W'(1);
      end
      if (retFire[c]) begin
        filled_d[c][bus.sc_xbar_rob_num_i] = 1'b1;
      end
      if (drainFire[c]) begin
        busy_d[c][headPtr_q[c]]   = 1'b0;
        filled_d[c][headPtr_q[c]] = 1'b0;
        headPtr_d[c]              = headPtr_q[c] + ROB_W'(1);
      end
      count_d[c] = count_q[c] + (ROB_W+1)'(allocFire[c]) - (ROB_W+1)'(drainFire[c]);
    end
    robErr_d = robErr_q | retErr;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int c = 0; c < NCH; c++) begin
        allocPtr_q[c] <= '0;
        headPtr_q[c]  <= '0;
        count_q[c]    <= '0;
        busy_q[c]     <= '0;
        filled_q[c]   <= '0;
      end
      robErr_q <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        allocPtr_q[c] <= allocPtr_d[c];
        headPtr_q[c]  <= headPtr_d[c];
        count_q[c]    <= count_d[c];
        busy_q[c]     <= busy_d[c];
        filled_q[c]   <= filled_d[c];
      end
      robErr_q <= robErr_d;
    end
  end

  // Payload storage is deliberately unreset; only the filled bits qualify it.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NCH; c++) begin
      if (retFire[c]) begin
        data_q[c][bus.sc_xbar_rob_num_i] <= bus.sc_xbar_data_i;
      end
    end
  end

  assign bus.xbar_rob_alloc_ready_o = allocReady;
  assign bus.xbar_rob_alloc_num_o   = allocNum;
  assign bus.sc_xbar_ready_o        = rst_i;
  assign bus.mcash_ch0_rtn_valid_o  = rtnValid[0];
  assign bus.mcash_ch1_rtn_valid_o  = rtnValid[1];
  assign bus.mcash_ch2_rtn_valid_o  = rtnValid[2];
  assign bus.mcash_ch0_rtn_data_o   = data_q[0][headPtr_q[0]];
  assign bus.mcash_ch1_rtn_data_o   = data_q[1][headPtr_q[1]];
  assign bus.mcash_ch2_rtn_data_o   = data_q[2][headPtr_q[2]];
  assign bus.rob_err_o              = robErr_q;
endmodule

// File: tb/tb_xbar_rtn_rob.sv
// Scoreboard bench for xbar_rtn_rob: data is queued per channel in allocation order and
// popped by a drain monitor; scenario tasks check grants, latency, stalls and errors inline.
module tb_xbar_rtn_rob;
  localparam int ROB_DEPTH = 4;
  localparam int ROB_W     = 2;
  localparam int DATA_W    = 128;

  logic clk = 1'b0;
  logic rstN;
  logic [2:0] rtnReady;
  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] expQ [3][$];
  logic [DATA_W-1:0] pendData [3][ROB_DEPTH];
  int                allocPtrM [3];
  logic [DATA_W-1:0] monExp;

  logic [2:0]        rtnValidV;
  logic [DATA_W-1:0] rtnDataV [3];

  xbar_rtn_rob_if #(.ROB_W(ROB_W), .DATA_W(DATA_W)) bus();

  xbar_rtn_rob #(.ROB_DEPTH(ROB_DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk_i (clk),
    .rst_i (rstN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mcash_ch0_rtn_ready_i = rtnReady[0];
  assign bus.mcash_ch1_rtn_ready_i = rtnReady[1];
  assign bus.mcash_ch2_rtn_ready_i = rtnReady[2];
  assign rtnValidV   = {bus.mcash_ch2_rtn_valid_o, bus.mcash_ch1_rtn_valid_o, bus.mcash_ch0_rtn_valid_o};
  assign rtnDataV[0] = bus.mcash_ch0_rtn_data_o;
  assign rtnDataV[1] = bus.mcash_ch1_rtn_data_o;
  assign rtnDataV[2] = bus.mcash_ch2_rtn_data_o;

  // Every handshaken return must match the oldest allocation still owed on that channel.
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      for (int c = 0; c < 3; c++) begin
        if (rtnValidV[c] === 1'b1 && rtnReady[c] === 1'b1) begin
          checks++;
          if (expQ[c].size() == 0) begin
            errors++;
            $display("[TB] FAIL drain_ch%0d got unexpected data %h, required no valid", c, rtnDataV[c]);
          end else begin
            monExp = expQ[c].pop_front();
            if (rtnDataV[c] !== monExp) begin
              errors++;
              $display("[TB] FAIL drain_ch%0d got %h, required %h", c, rtnDataV[c], monExp);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired, required finish before 100000");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DATA_W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    bus.sc_xbar_valid_i        = 1'b0;
    bus.xbar_rob_alloc_valid_i = 1'b0;
    rtnReady = 3'b111;
    for (int c = 0; c < 3; c++) begin
      expQ[c].delete();
      allocPtrM[c] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    step();
  endtask

  task automatic allocOne(input int ch, input logic [DATA_W-1:0] d,
                          output logic rdy, output logic [ROB_W-1:0] num);
    bus.xbar_rob_alloc_valid_i = 1'b1;
    bus.xbar_rob_alloc_ch_id_i = 2'(ch);
    #1;
    rdy = bus.xbar_rob_alloc_ready_o;
    num = bus.xbar_rob_alloc_num_o;
    @(posedge clk);
    #1;
    bus.xbar_rob_alloc_valid_i = 1'b0;
    pendData[ch][allocPtrM[ch]] = d;
    expQ[ch].push_back(d);
    allocPtrM[ch] = (allocPtrM[ch] + 1) % ROB_DEPTH;
  endtask

  task automatic sendReturn(input int ch, input int slot, input logic [DATA_W-1:0] d);
    bus.sc_xbar_valid_i   = 1'b1;
    bus.sc_xbar_ch_id_i   = 2'(ch);
    bus.sc_xbar_rob_num_i = ROB_W'(slot);
    bus.sc_xbar_data_i    = d;
    step();
    bus.sc_xbar_valid_i   = 1'b0;
  endtask

  task automatic waitDrain(input int ch);
    int n = 0;
    while (expQ[ch].size() != 0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (expQ[ch].size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout_ch%0d got %0d pending, required 0", ch, expQ[ch].size());
    end
    checks++;
    if (rtnValidV[ch] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ch%0d got valid=%b, required 0", ch, rtnValidV[ch]);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b1;
    bus.xbar_rob_alloc_valid_i = 1'b0;
    bus.xbar_rob_alloc_ch_id_i = 2'd3;
    bus.sc_xbar_valid_i        = 1'b0;
    #1;
    rstN = 1'b0;
    #1;
    checks++;
    if (rtnValidV !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_valid got %b, required 000", rtnValidV);
    end
    checks++;
    if (bus.rob_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_err got %b, required 0", bus.rob_err_o);
    end
    checks++;
    if (bus.xbar_rob_alloc_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_alloc_ch3 got %b, required 0", bus.xbar_rob_alloc_ready_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    bus.xbar_rob_alloc_ch_id_i = 2'd0;
    #1;
    checks++;
    if (bus.xbar_rob_alloc_ready_o !== 1'b1 || bus.xbar_rob_alloc_num_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_alloc_ch0 got ready=%b num=%0d, required ready=1 num=0",
               bus.xbar_rob_alloc_ready_o, bus.xbar_rob_alloc_num_o);
    end
    checks++;
    if (bus.sc_xbar_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sc_ready got %b, required 1", bus.sc_xbar_ready_o);
    end
    step();
  endtask

  task automatic test_in_order_drain();
    logic rdy;
    logic [ROB_W-1:0] num;
    int order [4] = '{2, 0, 3, 1};
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'hA000_0000 + 32'(i);
      allocOne(0, {4{w}}, rdy, num);
      checks++;
      if (rdy !== 1'b1 || num !== ROB_W'(i)) begin
        errors++;
        $display("[TB] FAIL alloc_ch0_%0d got ready=%b num=%0d, required ready=1 num=%0d", i, rdy, num, i);
      end
    end
    bus.xbar_rob_alloc_valid_i = 1'b1;
    bus.xbar_rob_alloc_ch_id_i = 2'd0;
    #1;
    checks++;
    if (bus.xbar_rob_alloc_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alloc_ch0_full got %b, required 0", bus.xbar_rob_alloc_ready_o);
    end
    bus.xbar_rob_alloc_valid_i = 1'b0;
    step();
    sendReturn(0, order[0], pendData[0][order[0]]);
    checks++;
    if (rtnValidV[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL head_not_ready got valid=%b, required 0", rtnValidV[0]);
    end
    sendReturn(0, order[1], pendData[0][order[1]]);
    checks++;
    if (rtnValidV[0] !== 1'b1 || rtnDataV[0] !== pendData[0][0]) begin
      errors++;
      $display("[TB] FAIL a0_latency got valid=%b data=%h, required valid=1 data=%h",
               rtnValidV[0], rtnDataV[0], pendData[0][0]);
    end
    sendReturn(0, order[2], pendData[0][order[2]]);
    checks++;
    if (rtnValidV[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL a1_gap got valid=%b, required 0", rtnValidV[0]);
    end
    sendReturn(0, order[3], pendData[0][order[3]]);
    checks++;
    if (rtnValidV[0] !== 1'b1 || rtnDataV[0] !== pendData[0][1]) begin
      errors++;
      $display("[TB] FAIL a1_latency got valid=%b data=%h, required valid=1 data=%h",
               rtnValidV[0], rtnDataV[0], pendData[0][1]);
    end
    waitDrain(0);
  endtask

  task automatic test_stall_independent();
    logic rdy;
    logic [ROB_W-1:0] num;
    rtnReady[1] = 1'b0;
    allocOne(1, rnd(), rdy, num);
    checks++;
    if (rdy !== 1'b1 || num !== '0) begin
      errors++;
      $display("[TB] FAIL alloc_ch1 got ready=%b num=%0d, required ready=1 num=0", rdy, num);
    end
    allocOne(2, rnd(), rdy, num);
    checks++;
    if (rdy !== 1'b1 || num !== '0) begin
      errors++;
      $display("[TB] FAIL alloc_ch2 got ready=%b num=%0d, required ready=1 num=0", rdy, num);
    end
    sendReturn(2, 0, pendData[2][0]);
    checks++;
    if (rtnValidV[2] !== 1'b1 || rtnDataV[2] !== pendData[2][0]) begin
      errors++;
      $display("[TB] FAIL ch2_return got valid=%b data=%h, required valid=1 data=%h",
               rtnValidV[2], rtnDataV[2], pendData[2][0]);
    end
    sendReturn(1, 0, pendData[1][0]);
    checks++;
    if (rtnValidV[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ch2_drained got valid=%b, required 0", rtnValidV[2]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rtnValidV[1] !== 1'b1 || rtnDataV[1] !== pendData[1][0]) begin
        errors++;
        $display("[TB] FAIL ch1_stall_%0d got valid=%b data=%h, required valid=1 data=%h",
                 k, rtnValidV[1], rtnDataV[1], pendData[1][0]);
      end
      step();
    end
    rtnReady[1] = 1'b1;
    waitDrain(1);
    waitDrain(2);
  endtask

  task automatic test_full_wrap();
    logic rdy;
    logic [ROB_W-1:0] num;
    int expNum;
    int order [4] = '{3, 1, 2, 0};
    rtnReady[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expNum = allocPtrM[0];
      allocOne(0, rnd(), rdy, num);
      checks++;
      if (rdy !== 1'b1 || num !== ROB_W'(expNum)) begin
        errors++;
        $display("[TB] FAIL refill_ch0_%0d got ready=%b num=%0d, required ready=1 num=%0d", i, rdy, num, expNum);
      end
    end
    sendReturn(0, 0, pendData[0][0]);
    rtnReady[0] = 1'b1;
    bus.xbar_rob_alloc_valid_i = 1'b1;
    bus.xbar_rob_alloc_ch_id_i = 2'd0;
    #1;
    checks++;
    if (bus.xbar_rob_alloc_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_drain_same_cycle got ready=%b, required 0", bus.xbar_rob_alloc_ready_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.xbar_rob_alloc_ready_o !== 1'b1 || bus.xbar_rob_alloc_num_o !== ROB_W'(allocPtrM[0])) begin
      errors++;
      $display("[TB] FAIL after_drain_alloc got ready=%b num=%0d, required ready=1 num=%0d",
               bus.xbar_rob_alloc_ready_o, bus.xbar_rob_alloc_num_o, allocPtrM[0]);
    end
    @(posedge clk);
    #1;
    bus.xbar_rob_alloc_valid_i = 1'b0;
    pendData[0][allocPtrM[0]] = rnd();
    expQ[0].push_back(pendData[0][allocPtrM[0]]);
    allocPtrM[0] = (allocPtrM[0] + 1) % ROB_DEPTH;
    checks++;
    if (bus.xbar_rob_alloc_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL refull got ready=%b, required 0", bus.xbar_rob_alloc_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      sendReturn(0, order[i], pendData[0][order[i]]);
    end
    waitDrain(0);
  endtask

  task automatic test_errors();
    logic rdy;
    logic [ROB_W-1:0] num;
    logic [DATA_W-1:0] dupData;
    applyReset();
    checks++;
    if (bus.rob_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear got %b, required 0", bus.rob_err_o);
    end
    sendReturn(1, 2, rnd());
    checks++;
    if (bus.rob_err_o !== 1'b1 || rtnValidV !== 3'b000) begin
      errors++;
      $display("[TB] FAIL err_not_busy got err=%b valid=%b, required err=1 valid=000", bus.rob_err_o, rtnValidV);
    end
    repeat (2) step();
    checks++;
    if (bus.rob_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky got %b, required 1", bus.rob_err_o);
    end

    applyReset();
    rtnReady[1] = 1'b0;
    allocOne(1, rnd(), rdy, num);
    sendReturn(1, 0, pendData[1][0]);
    checks++;
    if (bus.rob_err_o !== 1'b0 || rtnValidV[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL legal_return got err=%b valid=%b, required err=0 valid=1", bus.rob_err_o, rtnValidV[1]);
    end
    dupData = ~pendData[1][0];
    sendReturn(1, 0, dupData);
    checks++;
    if (bus.rob_err_o !== 1'b1 || rtnValidV[1] !== 1'b1 || rtnDataV[1] !== pendData[1][0]) begin
      errors++;
      $display("[TB] FAIL err_duplicate got err=%b valid=%b data=%h, required err=1 valid=1 data=%h",
               bus.rob_err_o, rtnValidV[1], rtnDataV[1], pendData[1][0]);
    end
    rtnReady[1] = 1'b1;
    waitDrain(1);

    applyReset();
    allocOne(0, rnd(), rdy, num);
    sendReturn(3, 0, pendData[0][0]);
    checks++;
    if (bus.rob_err_o !== 1'b1 || rtnValidV !== 3'b000) begin
      errors++;
      $display("[TB] FAIL err_ch3 got err=%b valid=%b, required err=1 valid=000", bus.rob_err_o, rtnValidV);
    end
    bus.xbar_rob_alloc_ch_id_i = 2'd3;
    #1;
    checks++;
    if (bus.xbar_rob_alloc_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alloc_ch3 got %b, required 0", bus.xbar_rob_alloc_ready_o);
    end
    step();
  endtask

  task automatic test_reset_mid_drain();
    logic rdy;
    logic [ROB_W-1:0] num;
    int order [3] = '{1, 2, 0};
    applyReset();
    checks++;
    if (bus.rob_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_reset_clear got %b, required 0", bus.rob_err_o);
    end
    rtnReady[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      allocOne(0, rnd(), rdy, num);
    end
    for (int i = 0; i < 3; i++) begin
      sendReturn(0, order[i], pendData[0][order[i]]);
    end
    rtnReady[0] = 1'b1;
    step();
    checks++;
    if (rtnValidV[0] !== 1'b1 || rtnDataV[0] !== pendData[0][1]) begin
      errors++;
      $display("[TB] FAIL mid_drain got valid=%b data=%h, required valid=1 data=%h",
               rtnValidV[0], rtnDataV[0], pendData[0][1]);
    end
    rstN = 1'b0;
    #1;
    checks++;
    if (rtnValidV !== 3'b000 || bus.sc_xbar_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got valid=%b sc_ready=%b, required valid=000 sc_ready=0",
               rtnValidV, bus.sc_xbar_ready_o);
    end
    for (int c = 0; c < 3; c++) begin
      expQ[c].delete();
      allocPtrM[c] = 0;
    end
    step();
    rstN = 1'b1;
    step();
    allocOne(0, rnd(), rdy, num);
    checks++;
    if (rdy !== 1'b1 || num !== '0) begin
      errors++;
      $display("[TB] FAIL alloc_after_reset got ready=%b num=%0d, required ready=1 num=0", rdy, num);
    end
  endtask

  initial begin
    rstN = 1'b1;
    rtnReady = 3'b111;
    bus.xbar_rob_alloc_valid_i = 1'b0;
    bus.xbar_rob_alloc_ch_id_i = 2'd0;
    bus.sc_xbar_valid_i        = 1'b0;
    bus.sc_xbar_ch_id_i        = 2'd0;
    bus.sc_xbar_rob_num_i      = '0;
    bus.sc_xbar_data_i         = '0;
    for (int c = 0; c < 3; c++) allocPtrM[c] = 0;
    test_reset();
    test_in_order_drain();
    test_stall_independent();
    test_full_wrap();
    test_errors();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
